ropuf_eval_ctrl: RTL

ROPUF_EVAL_CTRL -- requirements
Module: ropuf_eval_ctrl

---
 rtl/ropuf_pkg.sv | 21 ++
 rtl/ropuf_win_timer.sv | 37 +++
 rtl/ropuf_eval_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ropuf_pkg.sv
// ropuf_pkg -- shared constants and FSM state type for the RO-PUF evaluation
// controller.
//   WIN_LO   : lower edge of the comparator settle window
//   WIN_HI   : count value at which the comparator bit is captured
//   CNT_MAX  : last count value of each evaluation window
//   state_t  : evaluation FSM states
package ropuf_pkg;

    localparam logic [7:0] WIN_LO  = 8'd245;
    localparam logic [7:0] WIN_HI  = 8'd250;
    localparam logic [7:0] CNT_MAX = 8'd255;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_t;

endpackage

// File: rtl/ropuf_win_timer.sv
// ropuf_win_timer -- 8-bit evaluation window counter.
//   clk, rst   : clock, asynchronous active-high reset
//   i_clr      : synchronous clear (wins over i_en)
//   i_en       : increment enable, saturates at CNT_MAX
//   o_count    : current window count
//   o_at_win   : count == WIN_HI (capture point)
//   o_at_max   : count == CNT_MAX (last window cycle)
module ropuf_win_timer #(
    parameter logic [7:0] WIN_HI  = ropuf_pkg::WIN_HI,
    parameter logic [7:0] CNT_MAX = ropuf_pkg::CNT_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    output logic [7:0] o_count,
    output logic       o_at_win,
    output logic       o_at_max
);

    logic [7:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != CNT_MAX)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_count  = r_count;
    assign o_at_win = (r_count == WIN_HI);
    assign o_at_max = (r_count == CNT_MAX);

endmodule

// File: rtl/ropuf_eval_ctrl.sv
// ropuf_eval_ctrl -- sequences RO-pair evaluations and collects the PUF
// response one bit per pair.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : evaluation request (IDLE only)
//   cmp_bit    : RO-pair comparator output
//   resp_ack   : consumer acknowledge (DONE only)
//   count      : window count to the comparator
//   ro_en      : RO pair / counter enable
//   cnt_clr    : RO counter clear pulse
//   pair_sel   : index of the pair under evaluation
//   response   : collected response
//   resp_valid : response complete and stable
//   busy       : high in every state except IDLE
module ropuf_eval_ctrl #(
    parameter int unsigned RESP_BITS = 8,
    parameter logic [7:0]  WIN_HI    = 8'd250,
    parameter logic [7:0]  CNT_MAX   = 8'd255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         cmp_bit,
    input  logic                         resp_ack,
    output logic [7:0]                   count,
    output logic                         ro_en,
    output logic                         cnt_clr,
    output logic [$clog2(RESP_BITS)-1:0] pair_sel,
    output logic [RESP_BITS-1:0]         response,
    output logic                         resp_valid,
    output logic                         busy
);

    import ropuf_pkg::*;

    localparam int unsigned SEL_W = $clog2(RESP_BITS);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(RESP_BITS - 1);

    state_t                 r_state;
    logic                   r_ro_en;
    logic                   r_cnt_clr;
    logic                   r_resp_valid;
    logic                   r_busy;
    logic [SEL_W-1:0]       r_pair_sel;
    logic [RESP_BITS-1:0]   r_response;

    logic                   w_tmr_clr;
    logic                   w_tmr_en;
    logic                   w_at_win;
    logic                   w_at_max;

    // Counting only happens in RUN; every other state parks the counter at 0
    // on the following edge, so NEXT still shows CNT_MAX for its one cycle
    // while CLEAR and DONE see 0.
    assign w_tmr_clr = (r_state != S_RUN);
    assign w_tmr_en  = (r_state == S_RUN);

    ropuf_win_timer #(
        .WIN_HI  (WIN_HI),
        .CNT_MAX (CNT_MAX)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_count  (count),
        .o_at_win (w_at_win),
        .o_at_max (w_at_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ro_en      <= 1'b0;
            r_cnt_clr    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_pair_sel   <= '0;
            r_response   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_CLEAR;
                        r_pair_sel <= '0;
                        r_response <= '0;
                        r_cnt_clr  <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state   <= S_RUN;
                    r_cnt_clr <= 1'b0;
                    r_ro_en   <= 1'b1;
                end
                S_RUN: begin
                    if (w_at_win) begin
                        r_response[r_pair_sel] <= cmp_bit;
                    end
                    if (w_at_max) begin
                        r_state <= S_NEXT;
                        r_ro_en <= 1'b0;
                    end
                end
                S_NEXT: begin
                    if (r_pair_sel == LAST_SEL) begin
                        r_state      <= S_DONE;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_state    <= S_CLEAR;
                        r_pair_sel <= r_pair_sel + SEL_W'(1);
                        r_cnt_clr  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (resp_ack) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_ro_en      <= 1'b0;
                    r_cnt_clr    <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign ro_en      = r_ro_en;
    assign cnt_clr    = r_cnt_clr;
    assign resp_valid = r_resp_valid;
    assign busy       = r_busy;
    assign pair_sel   = r_pair_sel;
    assign response   = r_response;

endmodule
